// File: rtl/ll_page_mgr.sv
// ll_page_mgr: linked-list page manager for the shared packet buffer.
// Owns the page link memory ({last, next} per page) and the free-page list
// (head/tail/empty), and serves allocation, link write, link read and
// chain-return requests over srdy/drdy handshakes. One request is granted
// per cycle, which keeps the single-write / single-read link memory free of
// read/write hazards.
module ll_page_mgr #(
    parameter int pg_asz = 8
) (
    input  logic                clk,
    input  logic                reset,

    // page allocation request / response
    input  logic                par_srdy,
    output logic                par_drdy,
    output logic                parr_srdy,
    input  logic                parr_drdy,
    output logic [pg_asz-1:0]   parr_page,

    // link write {last, page, next}
    input  logic                lnp_srdy,
    output logic                lnp_drdy,
    input  logic [2*pg_asz:0]   lnp_pnp,

    // link read request / response
    input  logic                rlp_srdy,
    output logic                rlp_drdy,
    input  logic [pg_asz-1:0]   rlp_rd_page,
    output logic                rlpr_srdy,
    input  logic                rlpr_drdy,
    output logic [pg_asz:0]     rlpr_data,

    // chain return {start, end}
    input  logic                drf_srdy,
    output logic                drf_drdy,
    input  logic [2*pg_asz-1:0] drf_page_list,

    output logic                init_done
);

    localparam int n_pages = 2 ** pg_asz;
    localparam logic [pg_asz-1:0] last_page = {pg_asz{1'b1}};
    localparam logic [pg_asz-1:0] pg_zero   = '0;
    localparam logic [pg_asz-1:0] pg_one    = {{(pg_asz-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        st_init,
        st_idle,
        st_rlp_rsp,
        st_alc_rsp
    } state_t;

    state_t state, state_nxt;

    // request field decode
    logic              lnp_last;
    logic [pg_asz-1:0] lnp_page;
    logic [pg_asz-1:0] lnp_next;
    logic [pg_asz-1:0] drf_start;
    logic [pg_asz-1:0] drf_end;

    assign lnp_last  = lnp_pnp[2*pg_asz];
    assign lnp_page  = lnp_pnp[2*pg_asz-1:pg_asz];
    assign lnp_next  = lnp_pnp[pg_asz-1:0];
    assign drf_start = drf_page_list[2*pg_asz-1:pg_asz];
    assign drf_end   = drf_page_list[pg_asz-1:0];

    // free-list and bookkeeping state
    logic [pg_asz-1:0] head;
    logic [pg_asz-1:0] tail;
    logic              empty;
    logic [pg_asz-1:0] init_cnt;
    logic              head_pend;   // head must follow the link read this cycle

    // grants (exactly one winner at most, only in IDLE)
    logic gnt_lnp, gnt_drf, gnt_rlp, gnt_par;

    // link memory ports
    logic [pg_asz:0]   mem [n_pages];
    logic              mem_we;
    logic [pg_asz-1:0] mem_waddr;
    logic [pg_asz:0]   mem_wdata;
    logic              mem_re;
    logic [pg_asz-1:0] mem_raddr;
    logic [pg_asz:0]   rd_data;

    // state register; reset restarts initialisation from page 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= st_init;
        else       state <= state_nxt;
    end

    // next state and fixed-priority grant: lnp > drf > rlp > par
    always_comb begin
        state_nxt = state;
        gnt_lnp   = 1'b0;
        gnt_drf   = 1'b0;
        gnt_rlp   = 1'b0;
        gnt_par   = 1'b0;
        case (state)
            st_init: begin
                if (init_cnt == last_page) state_nxt = st_idle;
            end
            st_idle: begin
                if (lnp_srdy) begin
                    gnt_lnp = 1'b1;
                end else if (drf_srdy) begin
                    gnt_drf = 1'b1;
                end else if (rlp_srdy) begin
                    gnt_rlp   = 1'b1;
                    state_nxt = st_rlp_rsp;
                end else if (par_srdy && !empty) begin
                    // an empty list simply withholds par_drdy until a return
                    gnt_par   = 1'b1;
                    state_nxt = st_alc_rsp;
                end
            end
            st_rlp_rsp: begin
                if (rlpr_drdy) state_nxt = st_idle;
            end
            st_alc_rsp: begin
                if (parr_drdy) state_nxt = st_idle;
            end
            default: state_nxt = st_init;
        endcase
    end

    assign lnp_drdy  = gnt_lnp;
    assign drf_drdy  = gnt_drf;
    assign rlp_drdy  = gnt_rlp;
    assign par_drdy  = gnt_par;
    assign parr_srdy = (state == st_alc_rsp);
    assign rlpr_srdy = (state == st_rlp_rsp);
    assign rlpr_data = rd_data;

    // link memory port selection: init fill, link write, chain splice, reads
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = pg_zero;
        mem_wdata = '0;
        mem_re    = 1'b0;
        mem_raddr = pg_zero;
        if (state == st_init) begin
            mem_we    = 1'b1;
            mem_waddr = init_cnt;
            mem_wdata = (init_cnt == last_page) ? {1'b1, pg_zero}
                                                : {1'b0, init_cnt + pg_one};
        end
        if (gnt_lnp) begin
            mem_we    = 1'b1;
            mem_waddr = lnp_page;
            mem_wdata = {lnp_last, lnp_next};
        end
        if (gnt_drf && !empty) begin
            // splice the returned chain behind the current tail
            mem_we    = 1'b1;
            mem_waddr = tail;
            mem_wdata = {1'b0, drf_start};
        end
        if (gnt_rlp) begin
            mem_re    = 1'b1;
            mem_raddr = rlp_rd_page;
        end
        if (gnt_par) begin
            mem_re    = 1'b1;
            mem_raddr = head;
        end
    end

    // link memory write port (contents are rebuilt by init after reset)
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    // registered read port; holds its value while a response is stalled
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       rd_data <= '0;
        else if (mem_re) rd_data <= mem[mem_raddr];
    end

    // free-list pointers, init counter and allocation response page
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head      <= pg_zero;
            tail      <= pg_zero;
            empty     <= 1'b1;
            init_cnt  <= pg_zero;
            init_done <= 1'b0;
            parr_page <= pg_zero;
            head_pend <= 1'b0;
        end else begin
            if (state == st_init) begin
                init_cnt <= init_cnt + pg_one;
                if (init_cnt == last_page) begin
                    head      <= pg_zero;
                    tail      <= last_page;
                    empty     <= 1'b0;
                    init_done <= 1'b1;
                end
            end
            if (gnt_drf) begin
                tail <= drf_end;
                if (empty) begin
                    head  <= drf_start;
                    empty <= 1'b0;
                end
            end
            if (gnt_par) begin
                parr_page <= head;
                // last free page: head is stale but unused until a return
                if (head == tail) empty <= 1'b1;
                head_pend <= (head != tail);
            end
            // follow the link exactly once, in the first response cycle
            if (state == st_alc_rsp && head_pend) begin
                head      <= rd_data[pg_asz-1:0];
                head_pend <= 1'b0;
            end
        end
    end

endmodule
